// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch with one outstanding imem read, a small
//            {pc, insn} FIFO toward decode, redirect flush and halt detect.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] HALT_INSN = 32'h00002013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        de_valid,
    output logic [31:0] de_insn,
    output logic [31:0] de_pc,
    input  logic        de_ready,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    output logic        halted
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              r_state, w_state_n;
    logic                r_req, w_req_n;
    logic [31:0]         r_addr, w_addr_n;
    logic [31:0]         r_fetch_pc, w_fetch_pc_n;
    logic [31:0]         r_fifo_pc   [0:DEPTH-1];
    logic [31:0]         r_fifo_insn [0:DEPTH-1];
    logic [c_PTR_W-1:0]  r_wptr, r_rptr;
    logic [c_CNT_W-1:0]  r_count, w_count_next;
    logic                r_halted;

    logic                w_enq, w_deq, w_space, w_flush;
    logic [31:0]         w_target, w_addr_inc;

    function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
        f_inc = (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_target     = ex_target & 32'hFFFF_FFFC;
    assign w_addr_inc   = r_addr + 32'd4;
    // A redirect wins over everything: the returning word and the dequeue are both dropped.
    assign w_enq        = (r_state == S_WAIT) & imem_ack & ~ex_redirect;
    assign w_deq        = (r_count != '0) & de_ready & ~ex_redirect;
    assign w_count_next = r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_deq);
    assign w_space      = (w_count_next < c_DEPTH);
    assign w_flush      = ex_redirect;

    always_comb begin
        w_state_n    = r_state;
        w_req_n      = r_req;
        w_addr_n     = r_addr;
        w_fetch_pc_n = r_fetch_pc;
        if (ex_redirect) begin
            w_fetch_pc_n = w_target;
            case (r_state)
                S_WAIT, S_DRAIN: begin
                    if (imem_ack) begin
                        w_req_n   = 1'b1;
                        w_addr_n  = w_target;
                        w_state_n = S_WAIT;
                    end else begin
                        w_state_n = S_DRAIN;
                    end
                end
                default: begin
                    w_req_n   = 1'b1;
                    w_addr_n  = w_target;
                    w_state_n = S_WAIT;
                end
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_space) begin
                        w_req_n   = 1'b1;
                        w_addr_n  = r_fetch_pc;
                        w_state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        w_fetch_pc_n = w_addr_inc;
                        if (imem_rdata == HALT_INSN) begin
                            w_req_n   = 1'b0;
                            w_state_n = S_HALT;
                        end else if (w_space) begin
                            w_req_n   = 1'b1;
                            w_addr_n  = w_addr_inc;
                        end else begin
                            w_req_n   = 1'b0;
                            w_state_n = S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    // Stale response: drop it and chase the redirect target.
                    if (imem_ack) begin
                        w_req_n   = 1'b1;
                        w_addr_n  = r_fetch_pc;
                        w_state_n = S_WAIT;
                    end
                end
                default: begin
                    w_req_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_n;
            r_req      <= w_req_n;
            r_addr     <= w_addr_n;
            r_fetch_pc <= w_fetch_pc_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_pc[i]   <= '0;
                r_fifo_insn[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_fifo_pc[r_wptr]   <= r_addr;
                r_fifo_insn[r_wptr] <= imem_rdata;
                r_wptr              <= f_inc(r_wptr);
            end
            if (w_deq) begin
                r_rptr <= f_inc(r_rptr);
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (w_flush) begin
            r_halted <= 1'b0;
        end else if (w_deq && (r_fifo_insn[r_rptr] == HALT_INSN)) begin
            r_halted <= 1'b1;
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign de_valid  = (r_count != '0);
    assign de_insn   = r_fifo_insn[r_rptr];
    assign de_pc     = r_fifo_pc[r_rptr];
    assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage with a latency-
//            programmable instruction memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_HALT = 32'h00002013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        de_valid;
    logic [31:0] de_insn;
    logic [31:0] de_pc;
    logic        de_ready;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        halted;

    int          mem_lat;
    logic        halt_en;
    logic [31:0] halt_addr;
    int          wait_cnt;

    int          n_checks = 0;
    int          n_errors = 0;

    fetch_stage #(
        .RESET_PC  (32'h00000000),
        .DEPTH     (2),
        .HALT_INSN (c_HALT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .de_valid    (de_valid),
        .de_insn     (de_insn),
        .de_pc       (de_pc),
        .de_ready    (de_ready),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        pat = a ^ 32'hA500_0000;
    endfunction

    // Memory acks once the request has been held for mem_lat cycles.
    assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
    assign imem_rdata = (halt_en && imem_addr == halt_addr) ? c_HALT : pat(imem_addr);

    always @(posedge clk or posedge reset) begin
        if (reset)                      wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; de_ready = 1'b1; ex_redirect = 1'b0; ex_target = '0;
        mem_lat = 0; halt_en = 1'b0; halt_addr = 32'h8;
        step(); step();
        chk("rst_req",    32'(imem_req), 32'd0);
        chk("rst_addr",   imem_addr, 32'h0);
        chk("rst_valid",  32'(de_valid), 32'd0);
        chk("rst_insn",   de_insn, 32'h0);
        chk("rst_pc",     de_pc, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);

        // First fetch and streaming
        reset = 1'b0;
        step();
        chk("ff_req",   32'(imem_req), 32'd1);
        chk("ff_addr0", imem_addr, 32'h0);
        chk("ff_val0",  32'(de_valid), 32'd0);
        step();
        chk("ff_pc0",   de_pc, 32'h0);
        chk("ff_insn0", de_insn, pat(32'h0));
        chk("ff_addr4", imem_addr, 32'h4);
        step();
        chk("ff_pc4",   de_pc, 32'h4);
        chk("ff_req4",  32'(imem_req), 32'd1);
        step();
        chk("ff_pc8",   de_pc, 32'h8);
        chk("ff_addrc", imem_addr, 32'hC);

        // Backpressure: FIFO fills to two, request drops, head holds
        de_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_req",  32'(imem_req), 32'd0);
            chk("bp_pc",   de_pc, 32'h8);
            chk("bp_insn", de_insn, pat(32'h8));
        end
        de_ready = 1'b1;
        step();
        chk("bp_rel_pc",   de_pc, 32'hC);
        chk("bp_rel_addr", imem_addr, 32'h10);
        chk("bp_rel_req",  32'(imem_req), 32'd1);
        step();
        chk("bp_pc10", de_pc, 32'h10);
        step();
        chk("bp_pc14", de_pc, 32'h14);

        // Redirect while idle
        de_ready = 1'b0;
        step();
        chk("ri_req_idle", 32'(imem_req), 32'd0);
        chk("ri_valid",    32'(de_valid), 32'd1);
        ex_redirect = 1'b1; ex_target = 32'h00000103;
        step();
        ex_redirect = 1'b0; de_ready = 1'b1;
        chk("ri_flush", 32'(de_valid), 32'd0);
        chk("ri_req",   32'(imem_req), 32'd1);
        chk("ri_addr",  imem_addr, 32'h100);
        step();
        chk("ri_pc",   de_pc, 32'h100);
        chk("ri_insn", de_insn, pat(32'h100));

        // Redirect while waiting on a slow memory
        mem_lat = 3;
        step();
        chk("rw_empty", 32'(de_valid), 32'd0);
        chk("rw_addr1", imem_addr, 32'h104);
        ex_redirect = 1'b1; ex_target = 32'h00000200;
        step();
        ex_redirect = 1'b0;
        chk("rw_addr2", imem_addr, 32'h104);
        chk("rw_req2",  32'(imem_req), 32'd1);
        step();
        chk("rw_ack3",  32'(imem_ack), 32'd1);
        chk("rw_addr3", imem_addr, 32'h104);
        step();
        chk("rw_tgt",   imem_addr, 32'h200);
        chk("rw_noval", 32'(de_valid), 32'd0);
        mem_lat = 0;
        step();
        chk("rw_pc",   de_pc, 32'h200);
        chk("rw_insn", de_insn, pat(32'h200));

        // Halt at PC 8
        halt_en = 1'b1;
        ex_redirect = 1'b1; ex_target = 32'h0;
        step();
        ex_redirect = 1'b0;
        chk("h_addr0", imem_addr, 32'h0);
        chk("h_flush", 32'(de_valid), 32'd0);
        step();
        chk("h_pc0", de_pc, 32'h0);
        step();
        chk("h_pc4", de_pc, 32'h4);
        chk("h_addr8", imem_addr, 32'h8);
        step();
        chk("h_pc8",     de_pc, 32'h8);
        chk("h_insn",    de_insn, c_HALT);
        chk("h_noreq",   32'(imem_req), 32'd0);
        chk("h_notyet",  32'(halted), 32'd0);
        step();
        chk("h_halted",  32'(halted), 32'd1);
        chk("h_drained", 32'(de_valid), 32'd0);
        step();
        chk("h_noreq2",  32'(imem_req), 32'd0);
        chk("h_hold",    32'(halted), 32'd1);
        halt_en = 1'b0;
        ex_redirect = 1'b1; ex_target = 32'h300;
        step();
        ex_redirect = 1'b0;
        chk("h_clear",  32'(halted), 32'd0);
        chk("h_resume", imem_addr, 32'h300);
        chk("h_req",    32'(imem_req), 32'd1);
        step();
        chk("h_pc300", de_pc, 32'h300);

        // Asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        chk("ar_req",   32'(imem_req), 32'd0);
        chk("ar_valid", 32'(de_valid), 32'd0);
        chk("ar_addr",  imem_addr, 32'h0);
        step();
        reset = 1'b0;
        step();
        chk("ar_req1",  32'(imem_req), 32'd1);
        chk("ar_addr1", imem_addr, 32'h0);

        // PC wrap at the top of the address space
        ex_redirect = 1'b1; ex_target = 32'hFFFF_FFFF;
        step();
        ex_redirect = 1'b0;
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wr_pc",   de_pc, 32'hFFFF_FFFC);
        chk("wr_next", imem_addr, 32'h0);
        step();
        chk("wr_pc0",  de_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that feeds the decode stage of the RISC-V core. It issues word reads to instruction memory over a req/ack interface and buffers returned instructions with their PCs in a small FIFO. It presents them to decode over a valid/ready handshake and honours branch redirects from execute. It stops fetching once it captures the halt instruction `slti x0, x0, 0` (32'h00002013).

## Interface
- `RESET_PC`, default 32'h00000000: first fetch address after reset.
- `DEPTH`, default 2: FIFO entries (≥1, power of two).
- `HALT_INSN`, default 32'h00002013: encoding that stops fetch.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `imem_req` out 1: read request, held until ack.
- `imem_addr` out 32: word address of the request; bits [1:0] always 0.
- `imem_ack` in 1: request accepted and `imem_rdata` valid this cycle.
- `imem_rdata` in 32: instruction word.
- `de_valid` out 1: `de_insn`/`de_pc` hold a valid instruction.
- `de_insn` out 32: instruction at the FIFO head.
- `de_pc` out 32: PC of `de_insn`.
- `de_ready` in 1: decode accepts the head this cycle.
- `ex_redirect` in 1: flush and restart fetch at `ex_target`.
- `ex_target` in 32: redirect PC; bits [1:0] are ignored and forced to 0.
- `halted` out 1: the halt instruction has been consumed by decode.

## Operation
- **Registers**
  - `fetch_pc`: next address to request.
  - FIFO of {pc, insn}, `DEPTH` entries, with read/write pointers and a count.
  - State: IDLE, WAIT, DRAIN, HALT.
- **Outstanding requests:** at most one. `imem_req`/`imem_addr` are registered and stay stable from assertion until the cycle `imem_ack`=1.
- **IDLE:** issue a request at `fetch_pc` when `count_next` < `DEPTH`, then go to WAIT.
  - `count_next` = count after this cycle's enqueue and dequeue.
  - This reserves the slot for the returning word.
- **WAIT:** on `imem_ack`:
  - Enqueue {`imem_addr`, `imem_rdata`}.
  - `fetch_pc` <= `imem_addr`+4.
  - If `imem_rdata`==`HALT_INSN`: go to HALT and drop `imem_req`.
  - Otherwise, if space remains, keep `imem_req` high with the new address (back-to-back issue) and stay in WAIT; else go to IDLE.
- **DRAIN:** entered on a redirect while a request is outstanding. Keep `imem_req` and address unchanged until ack. Discard the returned data, then issue to `fetch_pc` (the target) and go to WAIT.
- **Redirect:** `ex_redirect` has the highest priority.
  - The FIFO is emptied (count=0) and `de_valid` goes low the next cycle.
  - `fetch_pc` <= {`ex_target`[31:2],2'b00}.
  - From IDLE/HALT: request the target next cycle, going to WAIT.
  - From WAIT with no ack this cycle: go to DRAIN.
  - From WAIT with ack this cycle: discard the data and request the target next cycle (WAIT).
  - A redirect in HALT leaves HALT; this covers a speculatively fetched halt instruction.
- **HALT:** no requests. The FIFO drains normally. `halted` sets on the cycle after the halt entry dequeues (`de_valid`&`de_ready` with `de_insn`==`HALT_INSN`). It stays set until reset or redirect.
- **Decode side:** `de_valid` = count≠0. `de_insn`/`de_pc` are the head entry, stable while `de_valid`&!`de_ready`.
- **Simultaneous events:**
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - A redirect with `de_ready` in the same cycle flushes; the dequeue is irrelevant.
- **PC arithmetic:** 32-bit, wraps from 32'hFFFFFFFC to 0.

## Timing
- **Reset values:** `imem_req`=0, `imem_addr`=`RESET_PC`, `de_valid`=0, `de_insn`=0, `de_pc`=0, `halted`=0. State IDLE, count 0, `fetch_pc`=`RESET_PC`.
- **After reset:** `imem_req` rises on the first rising edge after reset deasserts.
- **Latency:** ack in cycle N puts the entry at the FIFO head with `de_valid`=1 in N+1, when the FIFO was empty.
- **Throughput:** with ack every cycle and `de_ready`=1, one instruction per cycle; `imem_req` stays continuously high.
- **Redirect in cycle N:** `de_valid`=0 in N+1. The target request appears in N+1, or in the cycle after the discarded ack when draining.
- **Reset mid-operation:** all state returns to reset values immediately. Any outstanding memory response is not tracked; the memory model must also reset.

## Test plan
- **Reset/first fetch:** release reset with ack every cycle and `de_ready`=1 → `imem_addr` 0,4,8,… with `imem_req` continuous. `de_pc` 0,4,8 on consecutive cycles starting one cycle after the first ack.
- **Backpressure:** `de_ready`=0 for 10 cycles → FIFO fills with 2 entries and `imem_req` drops. `de_insn`/`de_pc` stay stable. On release, entries come out in order with no loss or duplication.
- **Redirect while idle:** redirect to 32'h00000103 → next request address is 32'h00000100 and FIFO contents are flushed. First `de_pc` after the redirect is 32'h100.
- **Redirect while waiting (ack delayed 3 cycles):** → `imem_addr` is unchanged until ack and the acked data never appears on `de_insn`. The next request is the target.
- **Halt:** memory returns 32'h00002013 at PC 8 → no requests after that ack. `halted`=1 the cycle after decode accepts PC 8. A subsequent redirect clears `halted` and fetch resumes.
- **Async reset mid-burst:** assert `reset` between clock edges → `imem_req`=0 and `de_valid`=0 immediately, without waiting for a clock edge.
